// File: rtl/em_pipe_buffer.sv
// Execute/Memory pipeline register with valid/ready handshake, flush squash and stall/flush counters.
// Define EMBUF_SKID_EN to add a second (skid) entry so ready_o becomes a registered signal.
module em_pipe_buffer #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              branch_i,
    input  logic              memToRead_i,
    input  logic              memToReg_i,
    input  logic              memToWrite_i,
    input  logic              regWrite_i,
    input  logic              zf_i,
    input  logic [DATA_W-1:0] branchAddr_i,
    input  logic [DATA_W-1:0] aluResult_i,
    input  logic [DATA_W-1:0] rtData_i,
    input  logic [REG_AW-1:0] writeAddrReg_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              branch_o,
    output logic              memToRead_o,
    output logic              memToReg_o,
    output logic              memToWrite_o,
    output logic              regWrite_o,
    output logic              zf_o,
    output logic [DATA_W-1:0] branchAddr_o,
    output logic [DATA_W-1:0] aluResult_o,
    output logic [DATA_W-1:0] rtData_o,
    output logic [REG_AW-1:0] writeAddrReg_o,
    output logic              branchTaken_o,
    output logic [CNT_W-1:0]  stallCnt_o,
    output logic [CNT_W-1:0]  flushCnt_o
);
    // Handshake: a bundle transfers on an edge where valid and ready are both high.
    localparam int BW = 3 * DATA_W + REG_AW;

    logic [5:0]    ctrl_in;
    logic [BW-1:0] data_in;
    logic          accept;
    logic          any_valid;

    logic          main_valid_q, main_valid_d;
    logic [5:0]    main_ctrl_q, main_ctrl_d;
    logic [BW-1:0] main_data_q, main_data_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    assign ctrl_in = {branch_i, memToRead_i, memToReg_i, memToWrite_i, regWrite_i, zf_i};
    assign data_in = {branchAddr_i, aluResult_i, rtData_i, writeAddrReg_i};
    assign accept  = valid_i & ready_o & ~flush_i;

`ifdef EMBUF_SKID_EN
    logic          skid_valid_q, skid_valid_d;
    logic [5:0]    skid_ctrl_q, skid_ctrl_d;
    logic [BW-1:0] skid_data_q, skid_data_d;
    logic          main_free;

    assign ready_o   = ~skid_valid_q;
    assign main_free = ~main_valid_q | ready_i;
    assign any_valid = main_valid_q | skid_valid_q;

    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                // Older skid entry advances first to keep FIFO order.
                main_valid_d = 1'b1;
                main_ctrl_d  = skid_ctrl_q;
                main_data_d  = skid_data_q;
                skid_valid_d = accept;
                skid_ctrl_d  = accept ? ctrl_in : 6'b0;
                if (accept) skid_data_d = data_in;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = ctrl_in;
                main_data_d  = data_in;
            end else if (main_valid_q) begin
                main_valid_d = 1'b0;
                main_ctrl_d  = '0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = ctrl_in;
            skid_data_d  = data_in;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    assign ready_o   = ~main_valid_q | ready_i;
    assign any_valid = main_valid_q;

    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
        end else if (accept) begin
            main_valid_d = 1'b1;
            main_ctrl_d  = ctrl_in;
            main_data_d  = data_in;
        end else if (main_valid_q & ready_i) begin
            // Bubble: squash control so memory stage cannot write, keep data.
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
        end
    end
`endif

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (main_valid_q & ~ready_i & (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_i & any_valid & (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign valid_o = main_valid_q;
    assign {branch_o, memToRead_o, memToReg_o, memToWrite_o, regWrite_o, zf_o} = main_ctrl_q;
    assign {branchAddr_o, aluResult_o, rtData_o, writeAddrReg_o} = main_data_q;
    assign branchTaken_o = main_valid_q & branch_o & zf_o;
    assign stallCnt_o    = stall_cnt_q;
    assign flushCnt_o    = flush_cnt_q;
endmodule
